// File: rtl/xdma_to_remote_arbiter.sv
// Fixed-priority arbiter sharing the to-remote write path (Finish=0, Grant=1, Cfg=2, Data=3),
// with per-packet locking, starvation aging and a single registered output stage.
module xdma_to_remote_arbiter #(
  parameter int unsigned NumInp      = 4,
  parameter int unsigned DataWidth   = 512,
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned StarveLimit = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumInp-1:0]           inp_valid_i,
  output logic [NumInp-1:0]           inp_ready_o,
  input  logic [NumInp*DataWidth-1:0] inp_data_i,
  input  logic [NumInp*AddrWidth-1:0] inp_addr_i,
  input  logic [NumInp-1:0]           inp_last_i,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [DataWidth-1:0]        oup_data_o,
  output logic [AddrWidth-1:0]        oup_addr_o,
  output logic                        oup_last_o,
  output logic                        oup_first_o,
  output logic [$clog2(NumInp)-1:0]   oup_idx_o,
  output logic                        busy_o
);

  localparam int unsigned IdxWidth = $clog2(NumInp);
  localparam logic [7:0]  AgeLimit = 8'(StarveLimit);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e                r_state, w_state_d;
  logic [IdxWidth-1:0]   r_lock_idx, w_lock_idx_d;
  logic [7:0]            r_age [NumInp];

  logic                  r_oup_valid;
  logic [DataWidth-1:0]  r_oup_data;
  logic [AddrWidth-1:0]  r_oup_addr;
  logic                  r_oup_last;
  logic                  r_oup_first;
  logic [IdxWidth-1:0]   r_oup_idx;

  logic                  w_can_load;
  logic                  w_any_valid;
  logic                  w_decision;
  logic                  w_accept;
  logic [NumInp-1:0]     w_urgent;
  logic [NumInp-1:0]     w_ready;
  logic [IdxWidth-1:0]   w_grant_idx;
  logic [IdxWidth-1:0]   w_sel_idx;
  logic                  w_sel_first;
  logic [DataWidth-1:0]  w_sel_data;
  logic [AddrWidth-1:0]  w_sel_addr;
  logic                  w_sel_last;

  assign w_can_load  = !r_oup_valid || oup_ready_i;
  assign w_any_valid = |inp_valid_i;
  assign w_decision  = (r_state == StUnlocked) && w_can_load && w_any_valid;
  assign w_accept    = |w_ready;

  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < NumInp; i++) begin
      w_urgent[i] = inp_valid_i[i] && (r_age[i] == AgeLimit);
    end
  end

  // Descending scan so the lowest matching index wins; urgent inputs pre-empt plain priority.
  always_comb begin
    w_grant_idx = '0;
    if (|w_urgent) begin
      for (int i = NumInp - 1; i >= 0; i--) begin
        if (w_urgent[i]) w_grant_idx = IdxWidth'(i);
      end
    end else begin
      for (int i = NumInp - 1; i >= 0; i--) begin
        if (inp_valid_i[i]) w_grant_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_lock_idx_d = r_lock_idx;
    w_ready      = '0;
    w_sel_idx    = r_lock_idx;
    w_sel_first  = 1'b0;
    case (r_state)
      StUnlocked: begin
        w_sel_idx   = w_grant_idx;
        w_sel_first = 1'b1;
        if (w_can_load && w_any_valid) begin
          w_ready[w_grant_idx] = 1'b1;
          if (!inp_last_i[w_grant_idx]) begin
            w_state_d    = StLocked;
            w_lock_idx_d = w_grant_idx;
          end
        end
      end
      StLocked: begin
        w_ready[r_lock_idx] = w_can_load && inp_valid_i[r_lock_idx];
        if (w_can_load && inp_valid_i[r_lock_idx] && inp_last_i[r_lock_idx]) begin
          w_state_d = StUnlocked;
        end
      end
      default: w_state_d = StUnlocked;
    endcase
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_addr = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NumInp; i++) begin
      if (w_sel_idx == IdxWidth'(i)) begin
        w_sel_data = inp_data_i[i*DataWidth +: DataWidth];
        w_sel_addr = inp_addr_i[i*AddrWidth +: AddrWidth];
        w_sel_last = inp_last_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StUnlocked;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_lock_idx <= w_lock_idx_d;
    end
  end

  // Ages move only when an arbitration decision is actually taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumInp; i++) r_age[i] <= '0;
    end else if (w_decision) begin
      for (int i = 0; i < NumInp; i++) begin
        if (w_ready[i]) begin
          r_age[i] <= '0;
        end else if (inp_valid_i[i]) begin
          r_age[i] <= (r_age[i] >= AgeLimit) ? AgeLimit : r_age[i] + 8'd1;
        end else begin
          r_age[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_oup_valid <= 1'b0;
      r_oup_data  <= '0;
      r_oup_addr  <= '0;
      r_oup_last  <= 1'b0;
      r_oup_first <= 1'b1;
      r_oup_idx   <= '0;
    end else if (w_accept) begin
      r_oup_valid <= 1'b1;
      r_oup_data  <= w_sel_data;
      r_oup_addr  <= w_sel_addr;
      r_oup_last  <= w_sel_last;
      r_oup_first <= w_sel_first;
      r_oup_idx   <= w_sel_idx;
    end else if (oup_ready_i) begin
      r_oup_valid <= 1'b0;
    end
  end

  assign inp_ready_o = w_ready;
  assign oup_valid_o = r_oup_valid;
  assign oup_data_o  = r_oup_data;
  assign oup_addr_o  = r_oup_addr;
  assign oup_last_o  = r_oup_last;
  assign oup_first_o = r_oup_first;
  assign oup_idx_o   = r_oup_idx;
  assign busy_o      = (r_state == StLocked) || r_oup_valid;

endmodule

// File: tb/tb_xdma_to_remote_arbiter.sv
// Directed and randomised checks of the to-remote arbiter: priority, locking, aging,
// backpressure, reset recovery and ordering under random traffic.
module tb_xdma_to_remote_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SL = 3;
  localparam int MaxPkt = 4;
  localparam int WaitBound = (SL + NI) * MaxPkt + MaxPkt;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     inp_valid;
  logic [NI-1:0]     inp_ready;
  logic [NI*DW-1:0]  inp_data;
  logic [NI*AW-1:0]  inp_addr;
  logic [NI-1:0]     inp_last;
  logic              oup_valid;
  logic              oup_ready;
  logic [DW-1:0]     oup_data;
  logic [AW-1:0]     oup_addr;
  logic              oup_last;
  logic              oup_first;
  logic [1:0]        oup_idx;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  xdma_to_remote_arbiter #(
    .NumInp(NI), .DataWidth(DW), .AddrWidth(AW), .StarveLimit(SL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inp_valid_i(inp_valid), .inp_ready_o(inp_ready), .inp_data_i(inp_data),
    .inp_addr_i(inp_addr), .inp_last_i(inp_last),
    .oup_valid_o(oup_valid), .oup_ready_i(oup_ready), .oup_data_o(oup_data),
    .oup_addr_o(oup_addr), .oup_last_o(oup_last), .oup_first_o(oup_first),
    .oup_idx_o(oup_idx), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input int i, input int seq, input logic last);
    logic [3:0]  iv;
    logic [26:0] sv;
    iv = i[3:0];
    sv = seq[26:0];
    return {iv, sv, last};
  endfunction

  function automatic logic [15:0] mk_addr(input int i, input int seq);
    logic [3:0]  iv;
    logic [11:0] sv;
    iv = i[3:0];
    sv = seq[11:0];
    return {iv, sv};
  endfunction

  task automatic set_src(input int i, input logic v, input logic last, input int seq);
    inp_valid[i] = v;
    inp_last[i]  = last;
    inp_data[i*DW +: DW] = mk_data(i, seq, last);
    inp_addr[i*AW +: AW] = mk_addr(i, seq);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int idx, input logic first,
                           input logic [31:0] data);
    check({tag, "_valid"}, oup_valid, 1'b1);
    check({tag, "_idx"}, oup_idx, idx[1:0]);
    check({tag, "_first"}, oup_first, first);
    check({tag, "_data"}, oup_data, data);
  endtask

  // Random-phase state
  logic [31:0] exp_q [NI][$];
  int          src_seq [NI];
  int          src_rem [NI];
  int          wait_cnt [NI];
  int          max_wait [NI];
  logic [NI-1:0] acc;
  logic [NI-1:0] held;
  logic [DW:0]   held_val [NI];
  logic          prev_last;
  int            prev_idx;
  int            ix;
  int            len;
  logic [31:0]   d;
  logic          gen_en;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fin_wait;
    int seq3 [8];
    int seq4 [4];
    seq3 = '{0, 0, 0, 2, 0, 0, 0, 2};
    seq4 = '{0, 0, 0, 2};

    inp_valid = '0; inp_last = '0; inp_data = '0; inp_addr = '0; oup_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", oup_valid, 1'b0);
    check("rst_first", oup_first, 1'b1);
    check("rst_idx", oup_idx, 2'd0);
    check("rst_last", oup_last, 1'b0);
    check("rst_data", oup_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", inp_ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Priority: Finish and Data together
    set_src(0, 1, 1, 0);
    set_src(3, 1, 1, 0);
    oup_ready = 1'b1;
    #1 check("t1_rdy0", inp_ready, 4'b0001);
    tick();
    check_out("t1_b0", 0, 1'b1, mk_data(0, 0, 1'b1));
    set_src(0, 0, 1, 0);
    #1 check("t1_rdy1", inp_ready, 4'b1000);
    tick();
    check_out("t1_b1", 3, 1'b1, mk_data(3, 0, 1'b1));
    check("t1_addr", oup_addr, mk_addr(3, 0));
    set_src(3, 0, 1, 0);
    tick();
    check("t1_drain", oup_valid, 1'b0);
    check("t1_busy", busy, 1'b0);

    // Locked 4-beat Data packet; Finish arrives at beat 2
    set_src(3, 1, 0, 0);
    #1 check("t2_rdy_b0", inp_ready, 4'b1000);
    tick();
    check_out("t2_b0", 3, 1'b1, mk_data(3, 0, 1'b0));
    set_src(3, 1, 0, 1);
    set_src(0, 1, 1, 5);
    fin_wait = 0;
    for (int b = 1; b <= 3; b++) begin
      #1 check("t2_rdy_lock", inp_ready, 4'b1000);
      if (inp_valid[0] && !inp_ready[0]) fin_wait++;
      tick();
      check_out("t2_b", 3, 1'b0, mk_data(3, b, b == 3));
      check("t2_busy", busy, 1'b1);
      if (b < 3) set_src(3, 1, (b + 1) == 3, b + 1);
      else set_src(3, 0, 1, 0);
    end
    check("t2_last", oup_last, 1'b1);
    check("t2_fin_wait", fin_wait, 3);
    #1 check("t2_rdy_fin", inp_ready, 4'b0001);
    tick();
    check_out("t2_fin", 0, 1'b1, mk_data(0, 5, 1'b1));
    set_src(0, 0, 1, 0);
    tick();
    check("t2_drain", oup_valid, 1'b0);

    // Starvation with StarveLimit=3
    set_src(0, 1, 1, 0);
    set_src(2, 1, 1, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t3_idx", oup_idx, seq3[k][1:0]);
      check("t3_first", oup_first, 1'b1);
    end

    // Backpressure with output full (holding input 2's beat)
    oup_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check("t4_rdy", inp_ready, 4'b0000);
      tick();
      check_out("t4_hold", 2, 1'b1, mk_data(2, 0, 1'b1));
    end
    oup_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_resume", oup_idx, seq4[k][1:0]);
      check("t4_valid", oup_valid, 1'b1);
    end
    set_src(0, 0, 1, 0);
    set_src(2, 0, 1, 0);
    tick();
    tick();
    check("t4_drain", oup_valid, 1'b0);

    // Reset mid-packet after beat 2 of 4, with a valid gap in between
    set_src(3, 1, 0, 0);
    tick();
    set_src(3, 1, 0, 1);
    tick();
    check_out("t5_b1", 3, 1'b0, mk_data(3, 1, 1'b0));
    set_src(3, 0, 0, 2);
    set_src(0, 1, 1, 7);
    #1 check("t5_gap_rdy", inp_ready, 4'b0000);
    tick();
    check("t5_gap_valid", oup_valid, 1'b0);
    check("t5_gap_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", oup_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t5_rdy_fin", inp_ready, 4'b0001);
    tick();
    check_out("t5_fin", 0, 1'b1, mk_data(0, 7, 1'b1));
    set_src(0, 0, 1, 0);
    tick();

    // Random traffic with scoreboard
    for (int i = 0; i < NI; i++) begin
      src_seq[i] = 0; src_rem[i] = 0; wait_cnt[i] = 0; max_wait[i] = 0;
      held_val[i] = '0;
    end
    prev_last = 1'b1;
    prev_idx  = 0;
    held      = '0;
    for (int cyc = 0; cyc < 10600; cyc++) begin
      gen_en = (cyc < 10000);
      @(negedge clk);
      if (!gen_en && inp_valid == '0 && !oup_valid) break;
      acc = inp_ready & inp_valid;
      check("rnd_onehot", $onehot0(inp_ready), 1'b1);
      if (oup_valid && oup_ready) begin
        ix = int'(oup_idx);
        check("rnd_qnonempty", exp_q[ix].size() != 0, 1'b1);
        if (exp_q[ix].size() != 0) begin
          d = exp_q[ix].pop_front();
          check("rnd_data", oup_data, d);
          check("rnd_addr", oup_addr, mk_addr(ix, int'(d[27:1])));
          check("rnd_last", oup_last, d[0]);
        end
        check("rnd_first", oup_first, prev_last);
        if (!prev_last) check("rnd_nointlv", ix, prev_idx);
        prev_last = oup_last;
        prev_idx  = ix;
      end
      for (int i = 0; i < NI; i++) begin
        if (acc[i]) begin
          exp_q[i].push_back(inp_data[i*DW +: DW]);
          wait_cnt[i] = 0;
        end else if (inp_valid[i] && (!oup_valid || oup_ready)) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
        end
        held[i]     = inp_valid[i] && !acc[i];
        held_val[i] = {inp_valid[i], inp_data[i*DW +: DW]};
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (acc[i]) begin
          src_seq[i]++;
          src_rem[i]--;
          if (src_rem[i] > 0) set_src(i, 1, src_rem[i] == 1, src_seq[i]);
          else inp_valid[i] = 1'b0;
        end
        if (!inp_valid[i] && gen_en && $urandom_range(0, 2) == 0) begin
          len = (i == 3) ? int'($urandom_range(1, MaxPkt)) : 1;
          src_rem[i] = len;
          set_src(i, 1, len == 1, src_seq[i]);
        end
        if (held[i]) check("src_hold", {inp_valid[i], inp_data[i*DW +: DW]}, held_val[i]);
      end
      oup_ready = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < NI; i++) begin
      check("rnd_drained", exp_q[i].size(), 0);
      check("rnd_idle", inp_valid[i], 1'b0);
      check("rnd_starve", max_wait[i] <= WaitBound, 1'b1);
      check("rnd_traffic", src_seq[i] > 100, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
